mem_stage: RTL and testbench

- Memory-access pipeline stage between exe_stage (upstream) and wb_stage (downstream).
- Registers the EXE-to-MEM bus and merges the synchronous data-SRAM read data into the load result.
- Forwards exception status downstream to WB and reports an in-flight exception back to EXE, which suppresses younger stores.
- Provides a bypass bus to the decode stage.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage.sv | 108 ++++++++++
 tb/tb_mem_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared bus widths, exception codes and bus layouts for the MEM pipeline stage.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 77;
    localparam int MS_TO_WS_BUS_WD = 76;
    localparam int MS_TO_ES_BUS_WD = 1;
    localparam int MS_TO_DS_BUS_WD = 38;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } ms_to_ds_t;

endpackage

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EXE bus, merges SRAM load data (holding it
// across WB stalls), forwards exceptions to WB/EXE and drives the decode bypass.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ms_flush,
    input  logic [31:0]                data_sram_rdata,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_ES_BUS_WD-1:0] ms_to_es_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

    logic        ms_valid_q, ms_valid_d;
    logic        rdata_held_q, rdata_held_d;
    logic [31:0] load_data_q;
    es_to_ms_t   es_bus_q;

    logic        ms_ready_go;
    logic        ms_fire;
    logic        bus_capture;
    logic        load_capture;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;
    ms_to_ds_t   ds_bus;

    // Handshake: a transfer happens on a cycle where the producer's valid and
    // the consumer's allowin are both high; valid never depends on allowin.
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign ms_fire        = ms_to_ws_valid && ws_allowin;
    assign bus_capture    = es_to_ms_valid && ms_allowin && !ms_flush;

    // SRAM data is only valid in the first MEM cycle, so keep a copy if WB stalls.
    assign load_capture = ms_valid_q && es_bus_q.res_from_mem && !rdata_held_q && !ms_fire;

    always_comb begin
        ms_valid_d = ms_valid_q;
        if (ms_flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
    end

    always_comb begin
        rdata_held_d = rdata_held_q;
        if (ms_flush || ms_fire) begin
            rdata_held_d = 1'b0;
        end else if (load_capture) begin
            rdata_held_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            rdata_held_q <= 1'b0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            rdata_held_q <= rdata_held_d;
        end
    end

    always_ff @(posedge clk) begin
        if (bus_capture) begin
            es_bus_q <= es_to_ms_t'(es_to_ms_bus);
        end
        if (load_capture) begin
            load_data_q <= data_sram_rdata;
        end
    end

    always_comb begin
        final_result = es_bus_q.alu_result;
        if (es_bus_q.res_from_mem) begin
            final_result = rdata_held_q ? load_data_q : data_sram_rdata;
        end
    end

    always_comb begin
        ws_bus.ex           = es_bus_q.ex;
        ws_bus.excode       = es_bus_q.excode;
        ws_bus.gr_we        = es_bus_q.gr_we;
        ws_bus.dest         = es_bus_q.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = es_bus_q.pc;
    end

    // Excepting or r0-targeted instructions must never be bypassed to decode.
    always_comb begin
        ds_bus.we   = ms_valid_q && es_bus_q.gr_we && !es_bus_q.ex && (es_bus_q.dest != 5'd0);
        ds_bus.dest = es_bus_q.dest;
        ds_bus.data = final_result;
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_to_ds_bus = ds_bus;
    assign ms_to_es_bus = ms_valid_q && es_bus_q.ex;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed vectors push expected WB/bypass/EXE
// bus values; a negedge monitor pops and compares on every WB transfer.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [76:0] es_to_ms_bus;
    logic        ms_flush;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [75:0] ms_to_ws_bus;
    logic [0:0]  ms_to_es_bus;
    logic [37:0] ms_to_ds_bus;

    // Entry layout: {es_bus[114], ds_bus[113:76], ws_bus[75:0]}
    logic [114:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_flush        (ms_flush),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_es_bus    (ms_to_es_bus),
        .ms_to_ds_bus    (ms_to_ds_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [76:0] mk_es(input logic ex, input logic [4:0] code,
                                          input logic rfm, input logic we,
                                          input logic [4:0] dest, input logic [31:0] alu,
                                          input logic [31:0] pc);
        return {ex, code, rfm, we, dest, alu, pc};
    endfunction

    task automatic expect_out(input logic ex, input logic [4:0] code, input logic we,
                              input logic [4:0] dest, input logic [31:0] res,
                              input logic [31:0] pc, input logic fwd_we);
        exp_q.push_back({ex, fwd_we, dest, res, ex, code, we, dest, res, pc});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction from EXE; on return it sits in MEM with rdata driven.
    task automatic send(input logic [76:0] bus, input logic [31:0] rdata);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = bus;
        tick();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = rdata;
    endtask

    always @(negedge clk) begin
        logic [114:0] e;
        if (reset === 1'b0 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got ws bus %h expected no transfer", ms_to_ws_bus);
            end else begin
                e = exp_q.pop_front();
                check("ws_bus", ms_to_ws_bus, e[75:0]);
                check("ds_bus", {38'd0, ms_to_ds_bus}, {38'd0, e[113:76]});
                check("es_bus", {75'd0, ms_to_es_bus}, {75'd0, e[114]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        ms_flush        = 1'b0;
        data_sram_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_ws_valid", ms_to_ws_valid, 0);
        check("rst_es_bus", ms_to_es_bus, 0);
        check("rst_fwd_we", ms_to_ds_bus[37], 0);
        check("rst_allowin", ms_allowin, 1);
        tick();
        reset = 1'b0;

        // ALU op: result comes from alu_result, not the SRAM.
        expect_out(0, 5'h0, 1, 5'd5, 32'h0000_1234, 32'hbfc0_0010, 1);
        send(mk_es(0, 5'h0, 0, 1, 5'd5, 32'h0000_1234, 32'hbfc0_0010), 32'h5555_5555);

        // Load: result comes from SRAM read data.
        expect_out(0, 5'h0, 1, 5'd7, 32'hdead_beef, 32'hbfc0_0014, 1);
        send(mk_es(0, 5'h0, 1, 1, 5'd7, 32'h0000_aaaa, 32'hbfc0_0014), 32'hdead_beef);

        // Back-to-back ALU ops: one per cycle, stage always accepting.
        for (int i = 0; i < 3; i++) begin
            logic [31:0] res;
            res = (i == 0) ? 32'h1 : (i == 1) ? 32'hffff_ffff : 32'h8000_0000;
            expect_out(0, 5'h0, 1, 5'(12 + i), res, 32'hbfc0_0100 + 32'(4 * i), 1);
            send(mk_es(0, 5'h0, 0, 1, 5'(12 + i), res, 32'hbfc0_0100 + 32'(4 * i)), 32'h0);
            @(negedge clk);
            check("b2b_valid", ms_to_ws_valid, 1);
            check("b2b_allowin", ms_allowin, 1);
        end
        tick();

        // Load with WB stalled for 3 cycles while rdata changes to zero.
        ws_allowin = 1'b0;
        expect_out(0, 5'h0, 1, 5'd8, 32'hdead_beef, 32'hbfc0_0020, 1);
        send(mk_es(0, 5'h0, 1, 1, 5'd8, 32'h0000_0001, 32'hbfc0_0020), 32'hdead_beef);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_allowin", ms_allowin, 0);
            check("stall_valid", ms_to_ws_valid, 1);
            check("stall_result", ms_to_ws_bus[63:32], 32'hdead_beef);
            tick();
            data_sram_rdata = 32'h0;
        end
        ws_allowin = 1'b1;
        tick();

        // Exception: passed through, reported to EXE, not bypassed.
        expect_out(1, EXC_ADEL, 1, 5'd9, 32'h0000_0bad, 32'hbfc0_0030, 0);
        send(mk_es(1, EXC_ADEL, 0, 1, 5'd9, 32'h0000_0bad, 32'hbfc0_0030), 32'h0);
        tick();
        @(negedge clk);
        check("ex_gone_es_bus", ms_to_es_bus, 0);

        // dest = 0 with gr_we = 1: no bypass.
        expect_out(0, 5'h0, 1, 5'd0, 32'h0000_0077, 32'hbfc0_0034, 0);
        send(mk_es(0, 5'h0, 0, 1, 5'd0, 32'h0000_0077, 32'hbfc0_0034), 32'h0);
        tick();

        // Flush kills a stalled excepting instruction while EXE offers another.
        ws_allowin = 1'b0;
        send(mk_es(1, EXC_ADES, 0, 0, 5'd3, 32'h0, 32'hbfc0_0040), 32'h0);
        @(negedge clk);
        check("held_ex_es_bus", ms_to_es_bus, 1);
        check("held_ex_allowin", ms_allowin, 0);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(0, 5'h0, 0, 1, 5'd4, 32'h1, 32'hbfc0_0044);
        ms_flush       = 1'b1;
        tick();
        ms_flush       = 1'b0;
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b1;
        @(negedge clk);
        check("flush_valid", ms_to_ws_valid, 0);
        check("flush_es_bus", ms_to_es_bus, 0);
        check("flush_allowin", ms_allowin, 1);

        // Flush on an empty stage beats an incoming instruction.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk_es(1, EXC_OV, 0, 1, 5'd6, 32'h2, 32'hbfc0_0048);
        ms_flush       = 1'b1;
        tick();
        ms_flush       = 1'b0;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("flush_empty_valid", ms_to_ws_valid, 0);
        check("flush_empty_es_bus", ms_to_es_bus, 0);
        tick();

        // Reset while a load is held; the next load must see fresh rdata.
        ws_allowin = 1'b0;
        send(mk_es(0, 5'h0, 1, 1, 5'd10, 32'h0, 32'hbfc0_0050), 32'hcafe_f00d);
        tick();
        data_sram_rdata = 32'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_stall_valid", ms_to_ws_valid, 0);
        check("rst_stall_fwd_we", ms_to_ds_bus[37], 0);
        check("rst_stall_allowin", ms_allowin, 1);
        ws_allowin = 1'b1;
        expect_out(0, 5'h0, 1, 5'd11, 32'h1234_5678, 32'hbfc0_0054, 1);
        send(mk_es(0, 5'h0, 1, 1, 5'd11, 32'h0, 32'hbfc0_0054), 32'h1234_5678);
        tick();
        tick();

        check("queue_drained", 76'(exp_q.size()), 76'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
